// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Byte-stream input, instruction-memory write port and core-control
//            status bundle for the boot-time program loader.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;
    logic [15:0]       loaded_words;

    modport slave (
        input  in_valid, in_data, reload,
        output in_ready, imem_we, imem_waddr, imem_wdata,
               core_reset, done, error, loaded_words
    );

    modport master (
        output in_valid, in_data, reload,
        input  in_ready, imem_we, imem_waddr, imem_wdata,
               core_reset, done, error, loaded_words
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Assembles a length-prefixed little-endian byte stream into 32-bit
//            words, writes them to instruction memory, then releases the core.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam logic [2:0]  c_LEN_LO = 3'd0;
    localparam logic [2:0]  c_LEN_HI = 3'd1;
    localparam logic [2:0]  c_DATA   = 3'd2;
    localparam logic [2:0]  c_FINISH = 3'd3;
    localparam logic [2:0]  c_DONE   = 3'd4;
    localparam logic [2:0]  c_ERR    = 3'd5;
    localparam logic [15:0] c_DEPTH  = 16'(DEPTH);

    logic [2:0]        r_state;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [1:0]        r_idx;
    logic [23:0]       r_buf;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic [15:0]       r_loaded;

    logic              w_ready;
    logic              w_accept;
    logic              w_reload;
    logic [15:0]       w_len_full;
    logic [15:0]       w_loaded_next;

    assign w_ready       = (r_state == c_LEN_LO) || (r_state == c_LEN_HI) || (r_state == c_DATA);
    assign w_accept      = bus.in_valid && w_ready;
    assign w_reload      = bus.reload && ((r_state == c_DONE) || (r_state == c_ERR));
    assign w_len_full    = {bus.in_data, r_len_lo};
    assign w_loaded_next = r_loaded + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_LEN_LO;
            r_len_lo <= 8'd0;
            r_len    <= 16'd0;
            r_idx    <= 2'd0;
            r_buf    <= 24'd0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= 32'd0;
            r_loaded <= 16'd0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                c_LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= bus.in_data;
                        r_state  <= c_LEN_HI;
                    end
                end
                c_LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len_full;
                        if ((w_len_full == 16'd0) || (w_len_full > c_DEPTH)) begin
                            r_state <= c_ERR;
                        end else begin
                            r_state <= c_DATA;
                        end
                    end
                end
                c_DATA: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_buf[7:0]   <= bus.in_data;
                            2'd1: r_buf[15:8]  <= bus.in_data;
                            2'd2: r_buf[23:16] <= bus.in_data;
                            default: begin
                                // Word complete: the write issues on the next cycle at the pre-increment count.
                                r_we     <= 1'b1;
                                r_waddr  <= r_loaded[ADDR_W-1:0];
                                r_wdata  <= {bus.in_data, r_buf};
                                r_loaded <= w_loaded_next;
                                if (w_loaded_next == r_len) begin
                                    r_state <= c_FINISH;
                                end
                            end
                        endcase
                    end
                end
                c_FINISH: begin
                    r_state <= c_DONE;
                end
                c_DONE, c_ERR: begin
                    if (w_reload) begin
                        r_state  <= c_LEN_LO;
                        r_loaded <= 16'd0;
                        r_idx    <= 2'd0;
                    end
                end
                default: begin
                    r_state <= c_LEN_LO;
                end
            endcase
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.imem_we      = r_we;
    assign bus.imem_waddr   = r_waddr;
    assign bus.imem_wdata   = r_wdata;
    assign bus.core_reset   = (r_state != c_DONE);
    assign bus.done         = (r_state == c_DONE);
    assign bus.error        = (r_state == c_ERR);
    assign bus.loaded_words = r_loaded;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader (DEPTH=256, ADDR_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_err;
    logic prev_we;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Log every write strobe and confirm it never lasts two cycles.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            check("we_single", 32'(prev_we), 32'd0);
            wr_addr.push_back(bus.imem_waddr);
            wr_data.push_back(bus.imem_wdata);
        end
        prev_we = bus.imem_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        bus.reload = 1'b1;
        @(posedge clk);
        #1;
        bus.reload = 1'b0;
    endtask

    task automatic offer_blocked(input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        repeat (3) tick();
        check("blocked_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_err        = 0;
        prev_we      = 1'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.reload   = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_in_ready",   32'(bus.in_ready),     32'd1);
        check("rst_we",         32'(bus.imem_we),      32'd0);
        check("rst_waddr",      32'(bus.imem_waddr),   32'd0);
        check("rst_wdata",      bus.imem_wdata,        32'd0);
        check("rst_core_reset", 32'(bus.core_reset),   32'd1);
        check("rst_done",       32'(bus.done),         32'd0);
        check("rst_error",      32'(bus.error),        32'd0);
        check("rst_loaded",     32'(bus.loaded_words), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_log();

        // Normal load, N=2, back-to-back bytes
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("w0_we",     32'(bus.imem_we),      32'd1);
        check("w0_addr",   32'(bus.imem_waddr),   32'd0);
        check("w0_data",   bus.imem_wdata,        32'h0000_0013);
        check("w0_loaded", 32'(bus.loaded_words), 32'd1);
        send_byte(8'hB3); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("w1_we",        32'(bus.imem_we),    32'd1);
        check("w1_addr",      32'(bus.imem_waddr), 32'd1);
        check("w1_data",      bus.imem_wdata,      32'h0000_00B3);
        check("fin_done",     32'(bus.done),       32'd0);
        check("fin_core_rst", 32'(bus.core_reset), 32'd1);
        check("fin_ready",    32'(bus.in_ready),   32'd0);
        tick();
        check("n2_done",     32'(bus.done),         32'd1);
        check("n2_core_rst", 32'(bus.core_reset),   32'd0);
        check("n2_loaded",   32'(bus.loaded_words), 32'd2);
        check("n2_we_low",   32'(bus.imem_we),      32'd0);
        check("n2_addr_hold",32'(bus.imem_waddr),   32'd1);
        check("n2_data_hold",bus.imem_wdata,        32'h0000_00B3);
        check("n2_wr_count", 32'(wr_addr.size()),   32'd2);
        check("n2_wr0_addr", 32'(wr_addr[0]),       32'd0);
        check("n2_wr0_data", wr_data[0],            32'h0000_0013);
        check("n2_wr1_addr", 32'(wr_addr[1]),       32'd1);
        check("n2_wr1_data", wr_data[1],            32'h0000_00B3);

        // Reload after DONE
        pulse_reload();
        check("rl_core_rst", 32'(bus.core_reset),   32'd1);
        check("rl_done",     32'(bus.done),         32'd0);
        check("rl_loaded",   32'(bus.loaded_words), 32'd0);
        check("rl_ready",    32'(bus.in_ready),     32'd1);
        clear_log();

        // Zero length header
        send_byte(8'h00); send_byte(8'h00);
        check("z_error",    32'(bus.error),      32'd1);
        check("z_core_rst", 32'(bus.core_reset), 32'd1);
        check("z_ready",    32'(bus.in_ready),   32'd0);
        offer_blocked(8'hAA);
        check("z_no_write", 32'(wr_addr.size()), 32'd0);
        pulse_reload();
        check("z_rl_error", 32'(bus.error),    32'd0);
        check("z_rl_ready", 32'(bus.in_ready), 32'd1);

        // N=1 with gaps, mid-word gap, and an ignored reload in DATA
        send_byte(8'h01); repeat ($urandom_range(0, 5)) tick();
        send_byte(8'h00); repeat ($urandom_range(0, 5)) tick();
        send_byte(8'hEF); repeat ($urandom_range(0, 5)) tick();
        send_byte(8'hBE); repeat (3) tick();
        pulse_reload();
        check("dr_ready",  32'(bus.in_ready),     32'd1);
        check("dr_loaded", 32'(bus.loaded_words), 32'd0);
        check("dr_error",  32'(bus.error),        32'd0);
        send_byte(8'hAD); repeat ($urandom_range(0, 5)) tick();
        check("g_no_write", 32'(wr_addr.size()), 32'd0);
        check("g_not_done", 32'(bus.done),       32'd0);
        send_byte(8'hDE);
        check("g_we",   32'(bus.imem_we),    32'd1);
        check("g_addr", 32'(bus.imem_waddr), 32'd0);
        check("g_data", bus.imem_wdata,      32'hDEAD_BEEF);
        tick();
        check("g_done",     32'(bus.done),         32'd1);
        check("g_loaded",   32'(bus.loaded_words), 32'd1);
        check("g_wr_count", 32'(wr_addr.size()),   32'd1);
        check("g_wr_data",  wr_data[0],            32'hDEAD_BEEF);

        // Oversize header N=257
        pulse_reload();
        clear_log();
        send_byte(8'h01); send_byte(8'h01);
        check("o_error",    32'(bus.error),      32'd1);
        check("o_core_rst", 32'(bus.core_reset), 32'd1);
        offer_blocked(8'h55);
        check("o_no_write", 32'(wr_addr.size()), 32'd0);

        // Reset mid-load, then a fresh N=1 load
        pulse_reload();
        send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        check("m_loaded", 32'(bus.loaded_words), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("m_rst_loaded",   32'(bus.loaded_words), 32'd0);
        check("m_rst_core_rst", 32'(bus.core_reset),   32'd1);
        check("m_rst_ready",    32'(bus.in_ready),     32'd1);
        check("m_rst_waddr",    32'(bus.imem_waddr),   32'd0);
        check("m_rst_wdata",    bus.imem_wdata,        32'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        check("f_addr", 32'(bus.imem_waddr), 32'd0);
        check("f_data", bus.imem_wdata,      32'h1234_5678);
        tick();
        check("f_done",     32'(bus.done),         32'd1);
        check("f_loaded",   32'(bus.loaded_words), 32'd1);
        check("f_wr_count", 32'(wr_addr.size()),   32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
